serial_mag_comp: RTL and testbench
==================================

Name: serial_mag_comp

Overview:
Bit-serial N-bit magnitude comparator. Accepts an operand pair over a valid/ready handshake and shifts the operands MSB-first, one bit per cycle, into a 1-bit comparator stage. It folds the per-bit gt/lt/eq outputs into a final one-hot result, which is returned over a valid/ready handshake. It is the sequential wrapper that feeds, and consumes the outputs of, the team's 1-bit comparator cell.

Parameters:
WIDTH, 8, operand width in bits; legal range is ≥1.
EARLY_EXIT, 1, 1: finish at the first differing bit; 0: always run WIDTH compare cycles (constant latency).

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand pair valid
in_ready  out  1  block can accept operands
a  in  WIDTH  operand A, unsigned
b  in  WIDTH  operand B, unsigned
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
a_gt_b  out  1  A > B
a_lt_b  out  1  A < B
a_eq_b  out  1  A == B
busy  out  1  high when state != IDLE

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n). rst_n low immediately forces state=IDLE, out_valid=0, a_gt_b=a_lt_b=a_eq_b=0, busy=0, shift registers=0, bit counter=0.
- States: IDLE, SHIFT, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready at an edge:
  - capture a→sh_a and b→sh_b;
  - set bit counter=WIDTH-1 and clear the decided flag;
  - go to SHIFT.
  - in_valid without acceptance has no effect.
- SHIFT: in_ready=0. The 1-bit cell compares sh_a[WIDTH-1] against sh_b[WIDTH-1] each cycle.
  - EARLY_EXIT=1:
    - bit gt or lt → latch that result (the other two flags 0), go to DONE;
    - bit eq with counter==0 → latch a_eq_b=1, go to DONE;
    - otherwise shift both registers left by 1 (zero fill), decrement the counter.
  - EARLY_EXIT=0:
    - the first non-eq bit latches gt/lt and sets the decided flag; later bits are ignored;
    - at counter==0 go to DONE;
    - if the flag is still clear at that point, latch eq.
- DONE: out_valid=1 and the results are held stable until out_valid&&out_ready; then go to IDLE and drop out_valid. The result flags keep their last value but are only meaningful while out_valid=1.
- Latency: out_valid rises k edges after the accept edge.
  - EARLY_EXIT=1: k = (index from MSB of the first differing bit)+1, or WIDTH when A==B.
  - EARLY_EXIT=0: k = WIDTH.
- Throughput: no new accept while SHIFT or DONE. The earliest next accept is the edge after the result handshake, since in_ready is registered-state based and does not bypass DONE.
- Invariant: while out_valid=1, exactly one of a_gt_b/a_lt_b/a_eq_b is 1.
- WIDTH=1: a single SHIFT cycle; the counter is sized max(1,$clog2(WIDTH)) bits.
- Reset mid-operation (SHIFT or DONE): the transaction is discarded and no out_valid pulse is produced. in_ready reads 1 during reset, but no capture occurs while rst_n is low.
- out_ready asserted while out_valid=0 is ignored.

Decomposition:
- Shared package comp_pkg holds:
  - the state enum (IDLE/SHIFT/DONE);
  - a 3-bit one-hot result encoding with constants RES_GT=3'b100, RES_LT=3'b010, RES_EQ=3'b001;
  - the default WIDTH.
- Sub-module: instantiate the existing one_bitcomp cell as the per-bit compare stage. No other sub-modules.

Test Plan:
1. WIDTH=8, EARLY_EXIT=1, a=0xA5, b=0xA5 → out_valid 8 edges after accept, a_eq_b=1, gt=lt=0.
2. a=0x80, b=0x7F → out_valid 1 edge after accept, a_gt_b=1; a=0x12, b=0x13 → out_valid 8 edges after accept, a_lt_b=1.
3. EARLY_EXIT=0, a=0x80, b=0x7F → a_gt_b=1 after exactly 8 edges; the later lower-bit lt decisions must not overwrite the result.
4. Result pending, out_ready held 0 for 5 cycles with in_valid=1 and changing a/b → out_valid and the flags stay stable, in_ready=0, no capture; out_ready=1 → IDLE next edge, then the next pair is accepted.
5. rst_n pulsed low 3 cycles after accepting a=0x0F, b=0xF0 → out_valid=0 and busy=0 immediately (asynchronous); after release, no stale result appears and a new pair 0x01/0x00 returns gt after 8 edges.
6. Back-to-back: 20 random pairs with random out_ready stalls → each result matches the reference comparison, with one-hot flags checked on every out_valid cycle.

Source files
------------

// File: rtl/comp_pkg.sv
// Shared types and constants for the bit-serial magnitude comparator.
package comp_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  // One-hot result encoding, ordered {gt, lt, eq}
  localparam logic [2:0] RES_GT = 3'b100;
  localparam logic [2:0] RES_LT = 3'b010;
  localparam logic [2:0] RES_EQ = 3'b001;

  localparam int unsigned DefaultWidth = 8;

endpackage

// File: rtl/one_bitcomp.sv
// Single-bit magnitude comparator cell.
module one_bitcomp (
  input  logic a_i,
  input  logic b_i,
  output logic gt_o,
  output logic lt_o,
  output logic eq_o
);

  assign gt_o = a_i & ~b_i;
  assign lt_o = ~a_i & b_i;
  assign eq_o = ~(a_i ^ b_i);

endmodule

// File: rtl/serial_mag_comp.sv
// Bit-serial N-bit magnitude comparator: shifts operands MSB-first through the
// 1-bit cell and folds the per-bit outcome into a one-hot result.
module serial_mag_comp
  import comp_pkg::*;
#(
  parameter int unsigned WIDTH      = DefaultWidth,
  parameter bit          EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             a_gt_b,
  output logic             a_lt_b,
  output logic             a_eq_b,
  output logic             busy
);

  localparam int unsigned    CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntInit = CntW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sh_a_q, sh_a_d;
  logic [WIDTH-1:0] sh_b_q, sh_b_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             decided_q, decided_d;
  logic [2:0]       res_q, res_d;

  logic       bit_gt, bit_lt, bit_eq;
  logic [2:0] bit_res;
  logic       last_bit;

  one_bitcomp u_cell (
    .a_i  (sh_a_q[WIDTH-1]),
    .b_i  (sh_b_q[WIDTH-1]),
    .gt_o (bit_gt),
    .lt_o (bit_lt),
    .eq_o (bit_eq)
  );

  assign bit_res  = bit_gt ? RES_GT : (bit_lt ? RES_LT : RES_EQ);
  assign last_bit = (cnt_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      sh_a_q    <= '0;
      sh_b_q    <= '0;
      cnt_q     <= '0;
      decided_q <= 1'b0;
      res_q     <= '0;
    end else begin
      state_q   <= state_d;
      sh_a_q    <= sh_a_d;
      sh_b_q    <= sh_b_d;
      cnt_q     <= cnt_d;
      decided_q <= decided_d;
      res_q     <= res_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid) state_d = StShift;
      StShift: if ((EARLY_EXIT && !bit_eq) || last_bit) state_d = StDone;
      StDone:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    sh_a_d    = sh_a_q;
    sh_b_d    = sh_b_q;
    cnt_d     = cnt_q;
    decided_d = decided_q;
    res_d     = res_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          sh_a_d    = a;
          sh_b_d    = b;
          cnt_d     = CntInit;
          decided_d = 1'b0;
        end
      end
      StShift: begin
        sh_a_d = sh_a_q << 1;
        sh_b_d = sh_b_q << 1;
        if (!last_bit) cnt_d = cnt_q - 1'b1;
        if (EARLY_EXIT) begin
          if (!bit_eq || last_bit) res_d = bit_res;
        end else if (!decided_q && !bit_eq) begin
          // First differing bit wins; lower bits no longer matter
          res_d     = bit_res;
          decided_d = 1'b1;
        end else if (!decided_q && last_bit) begin
          res_d = RES_EQ;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
    busy      = (state_q != StIdle);
    {a_gt_b, a_lt_b, a_eq_b} = res_q;
  end

endmodule

// File: tb/tb_serial_mag_comp.sv
// Self-checking bench: early-exit and constant-latency instances driven in lockstep
// against an arithmetic reference model.
module tb_serial_mag_comp;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] a, b;
  logic         out_ready;

  logic       in_ready_e, out_valid_e, busy_e;
  logic [2:0] res_e;
  logic       in_ready_c, out_valid_c, busy_c;
  logic [2:0] res_c;

  int n_vec = 0;
  int n_err = 0;

  serial_mag_comp #(.WIDTH(W), .EARLY_EXIT(1'b1)) u_dut_e (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready_e),
    .a         (a),
    .b         (b),
    .out_valid (out_valid_e),
    .out_ready (out_ready),
    .a_gt_b    (res_e[2]),
    .a_lt_b    (res_e[1]),
    .a_eq_b    (res_e[0]),
    .busy      (busy_e)
  );

  serial_mag_comp #(.WIDTH(W), .EARLY_EXIT(1'b0)) u_dut_c (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready_c),
    .a         (a),
    .b         (b),
    .out_valid (out_valid_c),
    .out_ready (out_ready),
    .a_gt_b    (res_c[2]),
    .a_lt_b    (res_c[1]),
    .a_eq_b    (res_c[0]),
    .busy      (busy_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  task automatic do_txn(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input int stall);
    logic [2:0] want;
    int         x, want_k, lat_e, lat_c;
    want   = (ta > tb_v) ? 3'b100 : ((ta < tb_v) ? 3'b010 : 3'b001);
    x      = int'(ta ^ tb_v);
    want_k = (x == 0) ? W : W + 1 - $clog2(x + 1);
    @(negedge clk);
    chk("ready_e", in_ready_e, 1);
    chk("ready_c", in_ready_c, 1);
    in_valid = 1'b1;
    a = ta;
    b = tb_v;
    @(negedge clk);
    in_valid = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    chk("busy_e", busy_e, 1);
    chk("busy_c", busy_c, 1);
    lat_e = 0;
    lat_c = 0;
    for (int j = 1; j <= 3 * W && (lat_e == 0 || lat_c == 0); j++) begin
      @(negedge clk);
      if (out_valid_e) begin
        if (lat_e == 0) lat_e = j;
        chk("res_e", res_e, want);
        chk("onehot_e", $countones(res_e), 1);
      end
      if (out_valid_c) begin
        if (lat_c == 0) lat_c = j;
        chk("res_c", res_c, want);
        chk("onehot_c", $countones(res_c), 1);
      end
    end
    chk("lat_e", lat_e, want_k);
    chk("lat_c", lat_c, W);
    for (int s = 0; s < stall; s++) begin
      in_valid = 1'b1;
      a = W'($urandom);
      b = W'($urandom);
      @(negedge clk);
      chk("hold_ov_e", out_valid_e, 1);
      chk("hold_res_e", res_e, want);
      chk("hold_rdy_e", in_ready_e, 0);
      chk("hold_ov_c", out_valid_c, 1);
      chk("hold_res_c", res_c, want);
      chk("hold_rdy_c", in_ready_c, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("drop_ov_e", out_valid_e, 0);
    chk("idle_e", {in_ready_e, busy_e}, 2'b10);
    chk("drop_ov_c", out_valid_c, 0);
    chk("idle_c", {in_ready_c, busy_c}, 2'b10);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    repeat (2) @(negedge clk);
    chk("rst_e", {in_ready_e, out_valid_e, busy_e, res_e}, 6'b100000);
    chk("rst_c", {in_ready_c, out_valid_c, busy_c, res_c}, 6'b100000);
    rst_n = 1'b1;

    // out_ready while idle must do nothing
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("idle_ordy", {out_valid_e, out_valid_c, busy_e, busy_c}, 4'b0000);

    do_txn(8'hA5, 8'hA5, 0);
    do_txn(8'h80, 8'h7F, 1);
    do_txn(8'h12, 8'h13, 0);
    do_txn(8'h80, 8'h7F, 5);

    // Asynchronous reset in the middle of a transaction
    @(negedge clk);
    in_valid = 1'b1;
    a = 8'h0F;
    b = 8'hF0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n    = 1'b0;
    in_valid = 1'b1;
    #1;
    chk("arst_e", {in_ready_e, out_valid_e, busy_e, res_e}, 6'b100000);
    chk("arst_c", {in_ready_c, out_valid_c, busy_c, res_c}, 6'b100000);
    repeat (2) @(negedge clk);
    chk("rst_nocap", {busy_e, busy_c}, 2'b00);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("no_stale", {out_valid_e, out_valid_c, busy_e, busy_c}, 4'b0000);
    end
    do_txn(8'h01, 8'h00, 0);

    for (int i = 0; i < 20; i++) begin
      ra = W'($urandom);
      case ($urandom_range(0, 2))
        0:       rb = W'($urandom);
        1:       rb = ra;
        default: rb = ra ^ W'(1 << $urandom_range(0, W - 1));
      endcase
      do_txn(ra, rb, int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
